stroke_plotter: RTL and testbench
=================================

Name: stroke_plotter

Overview:
- Downstream consumer of the per-digit stroke ROMs (idx → start/end/pen_down).
- On start, walks idx from 0 to stroke_cnt-1 and latches each segment.
- Bresenham-interpolates each segment into unit steps at a fixed step rate, driving position, step/dir pulses and the pen line for the plotter motor stage.
- Sits between the digit-select/ROM mux and the motor driver.

Parameters:
- STEP_DIV, 4, clock cycles per motion step (≥2).
- PEN_SETTLE, 8, cycles held after a pen level change before motion resumes (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  1-cycle request to plot a stroke list; ignored while busy
- abort  in  1  stop immediately
- stroke_cnt  in  5  number of strokes, sampled on accepted start
- idx  out  5  stroke index to ROM
- rom_en  out  1  ROM enable, high while busy
- seg_sx, seg_sy, seg_ex, seg_ey  in  8 each  ROM start/end coordinates
- seg_pen  in  1  ROM pen_down
- pos_x, pos_y  out  8 each  current plotter position
- pen  out  1  pen down
- step_x, step_y  out  1  1-cycle pulse per axis move
- dir_x, dir_y  out  1  1 = +direction; valid with step pulse
- busy  out  1  high from accepted start to DONE
- done  out  1  1-cycle pulse at list completion

Behaviour:
- Reset: state IDLE; idx=0, rom_en=0, pos_x=pos_y=0, pen=0, step_*=0, dir_*=0, busy=0, done=0, err=0.
- IDLE:
  - start && !abort → LOAD; idx=0, busy=1, rom_en=1; stroke_cnt latched.
  - If stroke_cnt==0, go DONE instead.
- LOAD (1 cycle): register seg_* (ROM is combinational, valid this cycle).
  - pos ← (seg_sx, seg_sy).
  - dx=|ex-sx|, dy=|ey-sy| as 9-bit unsigned.
  - dir_x = ex≥sx, dir_y = ey≥sy.
  - err = dx-dy as 11-bit signed.
  - → PEN.
- PEN:
  - If seg_pen≠pen: pen←seg_pen, wait PEN_SETTLE cycles, then → DRAW.
  - Else → DRAW next cycle.
- DRAW:
  - Step counter counts 0..STEP_DIV-1; a step executes when it hits STEP_DIV-1, so the first step comes STEP_DIV cycles after entry.
  - Per step: e2=2*err.
    - If e2>-dy: err-=dy, pos_x±1, step_x=1.
    - If e2<dx: err+=dx, pos_y±1, step_y=1.
    - Both axes may move in one step.
  - Segment ends when pos==end; this is checked before stepping, so a zero-length segment takes 0 steps.
  - Step count is exactly max(dx,dy).
  - → NEXT.
- NEXT:
  - idx==stroke_cnt-1 → DONE.
  - Else idx+1 → LOAD.
- DONE (1 cycle): done=1, busy=0, rom_en=0, idx=0, then IDLE. pos and pen hold their values.
- Abort, any state:
  - Next cycle IDLE, busy=0, rom_en=0, pen=0, no step pulse, no done.
  - pos holds.
  - Abort beats start in the same cycle.
- Arithmetic: no wrap. Coordinates stay within the 0..255 segment bounds by construction.
- step_x/step_y are never high outside DRAW. dir_* hold their last value.

Optional Feature:
- Macro STROKE_CONT_CHECK_EN.
- Defined:
  - Adds output err (1 bit, sticky, cleared on accepted start or reset).
  - In LOAD, if idx≠0 and (seg_sx,seg_sy)≠pos: err=1, pen=0, then → DONE. done pulses with err=1.
- Undefined:
  - No err port.
  - LOAD jumps pos to the segment start without checking.

Test Plan:
- Digit-4 list, ROM model (0,0→180,80 up; 180,80→60,80 down; 60,80→120,40 down; 120,40→120,120 down; 120,120→0,0 up), stroke_cnt=5, STEP_DIV=2 → expected results:
  - Step counts 180,120,60,80,120 (total 560).
  - pen rises once (before seg1) and falls once (before seg4).
  - Final pos (0,0); exactly one done pulse.
- Segment (10,10)→(13,10), STEP_DIV=4 → expected results:
  - 3 step_x pulses spaced 4 cycles, dir_x=1, no step_y.
  - First pulse 4 cycles after DRAW entry.
- Zero-length segment (50,50)→(50,50) with pen change, PEN_SETTLE=8 → pen toggles, 8-cycle hold, 0 steps, advances idx.
- Abort mid-DRAW of seg1 → next cycle busy=0, pen=0, pos frozen, no done. A later start replots from idx 0.
- start with stroke_cnt=0 → done after 1 cycle, busy high for 1 cycle, no steps. start while busy → ignored.
- STROKE_CONT_CHECK_EN: seg1 start (100,80) ≠ pos (180,80) → err=1, pen=0, done pulse, idx stops at 1.

Source files
------------

// File: rtl/stroke_plotter.sv
// Walks a per-digit stroke list from the ROM and Bresenham-interpolates each segment
// into timed unit steps for the motor stage. Define STROKE_CONT_CHECK_EN to add the err output.
module stroke_plotter #(
    parameter int STEP_DIV   = 4,
    parameter int PEN_SETTLE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] stroke_cnt,
    output logic [4:0] idx,
    output logic       rom_en,
    input  logic [7:0] seg_sx,
    input  logic [7:0] seg_sy,
    input  logic [7:0] seg_ex,
    input  logic [7:0] seg_ey,
    input  logic       seg_pen,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output logic       pen,
    output logic       step_x,
    output logic       step_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       busy,
    output logic       done,
`ifdef STROKE_CONT_CHECK_EN
    output logic       err,
`endif
    output logic [2:0] state_dbg
);

    // Handshake: start is taken only in IDLE with abort low; busy rises on the next
    // cycle and stays high until the single-cycle done pulse, where it falls.
    localparam int SDW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int PSW = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
    localparam logic [SDW-1:0] STEP_LAST = SDW'(STEP_DIV - 1);
    localparam logic [PSW-1:0] PEN_LAST  = PSW'(PEN_SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PEN, S_SETTLE, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t                state;
    logic        [4:0]     cnt_r;
    logic        [7:0]     ex_r;
    logic        [7:0]     ey_r;
    logic                  seg_pen_r;
    logic        [8:0]     dx_r;
    logic        [8:0]     dy_r;
    logic signed [10:0]    err_acc;
    logic        [SDW-1:0] step_cnt;
    logic        [PSW-1:0] settle_cnt;

    logic        [8:0]     ld_dx;
    logic        [8:0]     ld_dy;
    logic signed [10:0]    ld_err;
    logic signed [11:0]    e2;
    logic signed [11:0]    dx_w;
    logic signed [11:0]    dy_w;
    logic signed [11:0]    err_sum;
    logic                  move_x;
    logic                  move_y;
    logic                  at_end;
    logic                  cont_fault;

    assign state_dbg = state;
    assign at_end    = (pos_x == ex_r) && (pos_y == ey_r);

`ifdef STROKE_CONT_CHECK_EN
    assign cont_fault = (idx != 5'd0) && ((seg_sx != pos_x) || (seg_sy != pos_y));
`else
    assign cont_fault = 1'b0;
`endif

    // Segment set-up from the combinational ROM outputs seen during LOAD.
    always_comb begin
        ld_dx  = (seg_ex >= seg_sx) ? ({1'b0, seg_ex} - {1'b0, seg_sx})
                                    : ({1'b0, seg_sx} - {1'b0, seg_ex});
        ld_dy  = (seg_ey >= seg_sy) ? ({1'b0, seg_ey} - {1'b0, seg_sy})
                                    : ({1'b0, seg_sy} - {1'b0, seg_ey});
        ld_err = $signed({2'b00, ld_dx}) - $signed({2'b00, ld_dy});
    end

    // Both axis decisions use the same pre-step e2, so diagonal moves happen in one step.
    always_comb begin
        dx_w    = $signed({3'b000, dx_r});
        dy_w    = $signed({3'b000, dy_r});
        e2      = $signed({err_acc, 1'b0});
        move_x  = (e2 > -dy_w);
        move_y  = (e2 < dx_w);
        err_sum = $signed({err_acc[10], err_acc});
        if (move_x) err_sum = err_sum - dy_w;
        if (move_y) err_sum = err_sum + dx_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 5'd0;
            rom_en     <= 1'b0;
            pos_x      <= 8'd0;
            pos_y      <= 8'd0;
            pen        <= 1'b0;
            step_x     <= 1'b0;
            step_y     <= 1'b0;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_r      <= 5'd0;
            ex_r       <= 8'd0;
            ey_r       <= 8'd0;
            seg_pen_r  <= 1'b0;
            dx_r       <= 9'd0;
            dy_r       <= 9'd0;
            err_acc    <= 11'sd0;
            step_cnt   <= '0;
            settle_cnt <= '0;
`ifdef STROKE_CONT_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            step_x <= 1'b0;
            step_y <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                rom_en <= 1'b0;
                pen    <= 1'b0;
                idx    <= 5'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            idx    <= 5'd0;
                            busy   <= 1'b1;
                            rom_en <= 1'b1;
                            cnt_r  <= stroke_cnt;
`ifdef STROKE_CONT_CHECK_EN
                            err    <= 1'b0;
`endif
                            state  <= (stroke_cnt == 5'd0) ? S_DONE : S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (cont_fault) begin
`ifdef STROKE_CONT_CHECK_EN
                            err   <= 1'b1;
`endif
                            pen   <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            pos_x     <= seg_sx;
                            pos_y     <= seg_sy;
                            ex_r      <= seg_ex;
                            ey_r      <= seg_ey;
                            seg_pen_r <= seg_pen;
                            dx_r      <= ld_dx;
                            dy_r      <= ld_dy;
                            dir_x     <= (seg_ex >= seg_sx);
                            dir_y     <= (seg_ey >= seg_sy);
                            err_acc   <= ld_err;
                            state     <= S_PEN;
                        end
                    end
                    S_PEN: begin
                        if (seg_pen_r != pen) begin
                            pen        <= seg_pen_r;
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end else begin
                            step_cnt <= '0;
                            state    <= S_DRAW;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == PEN_LAST) begin
                            step_cnt <= '0;
                            state    <= S_DRAW;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_DRAW: begin
                        // End test precedes the step, so a zero-length segment never steps.
                        if (at_end) begin
                            state <= S_NEXT;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            err_acc  <= err_sum[10:0];
                            if (move_x) begin
                                pos_x  <= dir_x ? (pos_x + 8'd1) : (pos_x - 8'd1);
                                step_x <= 1'b1;
                            end
                            if (move_y) begin
                                pos_y  <= dir_y ? (pos_y + 8'd1) : (pos_y - 8'd1);
                                step_y <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (idx == cnt_r - 5'd1) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        rom_en <= 1'b0;
                        idx    <= 5'd0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stroke_plotter.sv
// Bench for stroke_plotter: directed timing cases plus random chained stroke lists
// checked against per-segment step totals, line deviation and pen transitions.
module tb_stroke_plotter;
    localparam int STEP_DIV   = 4;
    localparam int PEN_SETTLE = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [4:0] stroke_cnt;
    logic [4:0] idx;
    logic       rom_en;
    logic [7:0] seg_sx, seg_sy, seg_ex, seg_ey;
    logic       seg_pen;
    logic [7:0] pos_x, pos_y;
    logic       pen, step_x, step_y, dir_x, dir_y, busy, done;
    logic [2:0] state_dbg;
`ifdef STROKE_CONT_CHECK_EN
    logic       err;
`endif

    logic [7:0] rom_sx [32];
    logic [7:0] rom_sy [32];
    logic [7:0] rom_ex [32];
    logic [7:0] rom_ey [32];
    logic       rom_pen [32];

    assign seg_sx  = rom_sx[idx];
    assign seg_sy  = rom_sy[idx];
    assign seg_ex  = rom_ex[idx];
    assign seg_ey  = rom_ey[idx];
    assign seg_pen = rom_pen[idx];

    stroke_plotter #(.STEP_DIV(STEP_DIV), .PEN_SETTLE(PEN_SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stroke_cnt(stroke_cnt),
        .idx(idx), .rom_en(rom_en), .seg_sx(seg_sx), .seg_sy(seg_sy), .seg_ex(seg_ex),
        .seg_ey(seg_ey), .seg_pen(seg_pen), .pos_x(pos_x), .pos_y(pos_y), .pen(pen),
        .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y), .busy(busy),
        .done(done),
`ifdef STROKE_CONT_CHECK_EN
        .err(err),
`endif
        .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: per-segment step tallies and path sanity, cleared on request
    int mon_ev [32];
    int mon_x [32];
    int mon_y [32];
    int mon_done, mon_rise, mon_fall, mon_trk, mon_line, mon_pen, mon_dir, mon_idx_max;
    int clr_gen = 0;
    int last_gen = 0;
    logic [7:0] prev_x = 8'd0;
    logic [7:0] prev_y = 8'd0;
    logic       prev_pen = 1'b0;

    always @(negedge clk) begin : mon
        int sx, sy, ex, ey, cr, mj;
        if (clr_gen != last_gen) begin
            last_gen = clr_gen;
            for (int i = 0; i < 32; i++) begin
                mon_ev[i] = 0; mon_x[i] = 0; mon_y[i] = 0;
            end
            mon_done = 0; mon_rise = 0; mon_fall = 0; mon_trk = 0;
            mon_line = 0; mon_pen = 0; mon_dir = 0; mon_idx_max = 0;
        end
        if (done) mon_done++;
        if (pen && !prev_pen) mon_rise++;
        if (!pen && prev_pen) mon_fall++;
        if (busy && int'(idx) > mon_idx_max) mon_idx_max = int'(idx);
        if (step_x || step_y) begin
            sx = int'(rom_sx[idx]); sy = int'(rom_sy[idx]);
            ex = int'(rom_ex[idx]); ey = int'(rom_ey[idx]);
            mon_ev[idx]++;
            if (step_x) begin
                mon_x[idx]++;
                if (int'(pos_x) != int'(prev_x) + (dir_x ? 1 : -1)) mon_trk++;
                if (dir_x != (ex >= sx)) mon_dir++;
            end else if (pos_x != prev_x) mon_trk++;
            if (step_y) begin
                mon_y[idx]++;
                if (int'(pos_y) != int'(prev_y) + (dir_y ? 1 : -1)) mon_trk++;
                if (dir_y != (ey >= sy)) mon_dir++;
            end else if (pos_y != prev_y) mon_trk++;
            if (pen !== rom_pen[idx]) mon_pen++;
            cr = (int'(pos_x) - sx) * (ey - sy) - (int'(pos_y) - sy) * (ex - sx);
            mj = imax(iabs(ex - sx), iabs(ey - sy));
            if (iabs(cr) > mj) mon_line++;
        end
        prev_x   = pos_x;
        prev_y   = pos_y;
        prev_pen = pen;
    end

    // Driver tasks
    task automatic set_seg(input int i, input int sx, input int sy, input int ex, input int ey,
                           input bit p);
        rom_sx[i] = 8'(sx); rom_sy[i] = 8'(sy);
        rom_ex[i] = 8'(ex); rom_ey[i] = 8'(ey);
        rom_pen[i] = p;
    endtask

    task automatic mon_clear();
        @(negedge clk);
        clr_gen = clr_gen + 1;
        @(negedge clk);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        stroke_cnt = 5'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic run_list(input string tag, input int n, input int budget);
        int seen;
        seen = 0;
        mon_clear();
        do_start(n);
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, seen, 1);
        repeat (5) @(negedge clk);
    endtask

    // Scoreboard for a completed list: totals derived from the segment geometry
    task automatic check_list(input string tag, input int n, input bit pen0);
        int p, rises, falls, dx, dy;
        p = pen0; rises = 0; falls = 0;
        for (int i = 0; i < n; i++) begin
            dx = iabs(int'(rom_ex[i]) - int'(rom_sx[i]));
            dy = iabs(int'(rom_ey[i]) - int'(rom_sy[i]));
            check($sformatf("%s_steps%0d", tag, i), mon_ev[i], imax(dx, dy));
            check($sformatf("%s_xsteps%0d", tag, i), mon_x[i], dx);
            check($sformatf("%s_ysteps%0d", tag, i), mon_y[i], dy);
            if (rom_pen[i] && p == 0) rises++;
            if (!rom_pen[i] && p == 1) falls++;
            p = int'(rom_pen[i]);
        end
        check({tag, "_rise"}, mon_rise, rises);
        check({tag, "_fall"}, mon_fall, falls);
        check({tag, "_done_cnt"}, mon_done, 1);
        check({tag, "_pos_x"}, pos_x, rom_ex[n-1]);
        check({tag, "_pos_y"}, pos_y, rom_ey[n-1]);
        check({tag, "_pen"}, pen, rom_pen[n-1]);
        check({tag, "_track"}, mon_trk, 0);
        check({tag, "_line"}, mon_line, 0);
        check({tag, "_penstep"}, mon_pen, 0);
        check({tag, "_dir"}, mon_dir, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idx_max"}, mon_idx_max, n - 1);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int ny, done_c, rise_c, first_c, first_idx, px, py, snap, sum, n, budget;
        bit cur_pen;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stroke_cnt = 5'd0;
        for (int i = 0; i < 32; i++) set_seg(i, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_idx", idx, 0);       check("rst_rom_en", rom_en, 0);
        check("rst_pos_x", pos_x, 0);   check("rst_pos_y", pos_y, 0);
        check("rst_pen", pen, 0);       check("rst_step", {step_x, step_y}, 0);
        check("rst_dir", {dir_x, dir_y}, 0);
        check("rst_busy", busy, 0);     check("rst_done", done, 0);
`ifdef STROKE_CONT_CHECK_EN
        check("rst_err", err, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Horizontal 3-step segment: pulse timing relative to start
        set_seg(0, 10, 10, 13, 10, 1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(8'(3 + STEP_DIV * (k + 1)));
        mon_clear();
        do_start(1);
        check("a_busy", busy, 1);
        check("a_rom_en", rom_en, 1);
        ny = 0; done_c = 0;
        for (int c = 1; c <= 40; c++) begin
            if (step_x) begin
                if (exp_q.size() == 0) check("a_extra_step", c, 0);
                else check("a_step_cycle", c, int'(exp_q.pop_front()));
                check("a_dir_x", dir_x, 1);
            end
            if (step_y) ny++;
            if (done && done_c == 0) done_c = c;
            @(negedge clk);
        end
        check("a_missing_steps", exp_q.size(), 0);
        check("a_no_step_y", ny, 0);
        check("a_done_cycle", done_c, 6 + 3 * STEP_DIV);
        check("a_pos_x", pos_x, 13);
        check("a_pos_y", pos_y, 10);

        // Zero-length segment with pen change, then a short segment
        set_seg(0, 50, 50, 50, 50, 1'b1);
        set_seg(1, 50, 50, 52, 50, 1'b1);
        mon_clear();
        do_start(2);
        rise_c = 0; first_c = 0; first_idx = -1; done_c = 0;
        for (int c = 1; c <= 80; c++) begin
            if (pen && rise_c == 0) rise_c = c;
            if ((step_x || step_y) && first_c == 0) begin
                first_c = c;
                first_idx = int'(idx);
            end
            if (done && done_c == 0) done_c = c;
            @(negedge clk);
        end
        check("z_pen_rise", rise_c, 3);
        check("z_first_step", first_c, 7 + PEN_SETTLE + STEP_DIV);
        check("z_first_idx", first_idx, 1);
        check("z_zero_steps", mon_ev[0], 0);
        check("z_seg1_steps", mon_x[1], 2);
        check("z_done_cycle", done_c, 10 + PEN_SETTLE + 2 * STEP_DIV);

        // Abort beats start while idle; abort drops pen
        @(negedge clk);
        abort = 1'b1; start = 1'b1; stroke_cnt = 5'd5;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("ia_busy", busy, 0);
        check("ia_pen", pen, 0);
        check("ia_rom_en", rom_en, 0);
        repeat (3) @(negedge clk);
        check("ia_busy_later", busy, 0);

        // Digit-4 list
        set_seg(0, 0, 0, 180, 80, 1'b0);
        set_seg(1, 180, 80, 60, 80, 1'b1);
        set_seg(2, 60, 80, 120, 40, 1'b1);
        set_seg(3, 120, 40, 120, 120, 1'b1);
        set_seg(4, 120, 120, 0, 0, 1'b0);
        run_list("d4", 5, 4000);
        check_list("d4", 5, 1'b0);
        sum = 0;
        for (int i = 0; i < 5; i++) sum += mon_ev[i];
        check("d4_total", sum, 560);

        // Abort during seg1 draw
        mon_clear();
        do_start(5);
        snap = 0;
        for (int c = 0; c < 3000; c++) begin
            if (idx == 5'd1 && mon_ev[1] >= 10) begin
                snap = 1;
                break;
            end
            @(negedge clk);
        end
        check("ab_reached", snap, 1);
        px = int'(pos_x); py = int'(pos_y);
        check("ab_pen_before", pen, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_pen", pen, 0);
        check("ab_rom_en", rom_en, 0);
        check("ab_step", {step_x, step_y}, 0);
        check("ab_done", done, 0);
        check("ab_pos_x", pos_x, px);
        check("ab_pos_y", pos_y, py);
        snap = 0;
        for (int i = 0; i < 5; i++) snap += mon_ev[i];
        repeat (20) @(negedge clk);
        sum = 0;
        for (int i = 0; i < 5; i++) sum += mon_ev[i];
        check("ab_no_more_steps", sum, snap);
        check("ab_no_done", mon_done, 0);
        check("ab_pos_x_hold", pos_x, px);

        // Restart replots the whole list from idx 0
        run_list("rs", 5, 4000);
        check_list("rs", 5, 1'b0);

        // Empty list
        mon_clear();
        do_start(0);
        check("e_busy_c1", busy, 1);
        check("e_done_c1", done, 0);
        @(negedge clk);
        check("e_busy_c2", busy, 0);
        check("e_done_c2", done, 1);
        @(negedge clk);
        check("e_done_c3", done, 0);
        sum = 0;
        for (int i = 0; i < 32; i++) sum += mon_ev[i];
        check("e_no_steps", sum, 0);

        // Start while busy is ignored
        set_seg(0, 20, 20, 23, 21, 1'b0);
        mon_clear();
        do_start(1);
        repeat (3) @(negedge clk);
        do_start(3);
        for (int c = 0; c < 200; c++) begin
            if (mon_done > 0) break;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check("sb_done_cnt", mon_done, 1);
        check("sb_idx_max", mon_idx_max, 0);
        check("sb_steps", mon_ev[0], 3);
        check("sb_busy", busy, 0);

        // Random chained lists
        cur_pen = 1'b0;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            px = $urandom_range(0, 255); py = $urandom_range(0, 255);
            budget = 100;
            for (int i = 0; i < n; i++) begin
                int ex, ey;
                ex = $urandom_range(0, 255); ey = $urandom_range(0, 255);
                if ($urandom_range(0, 4) == 0) begin ex = px; ey = py; end
                set_seg(i, px, py, ex, ey, 1'($urandom_range(0, 1)));
                budget += imax(iabs(ex - px), iabs(ey - py)) * STEP_DIV + PEN_SETTLE + 10;
                px = ex; py = ey;
            end
            run_list($sformatf("rnd%0d", r), n, budget);
            check_list($sformatf("rnd%0d", r), n, cur_pen);
            cur_pen = rom_pen[n-1];
        end

`ifdef STROKE_CONT_CHECK_EN
        // Discontinuous second stroke
        set_seg(0, 0, 0, 180, 80, 1'b1);
        set_seg(1, 100, 80, 60, 80, 1'b1);
        run_list("ce", 2, 2000);
        check("ce_err", err, 1);
        check("ce_pen", pen, 0);
        check("ce_done_cnt", mon_done, 1);
        check("ce_idx_max", mon_idx_max, 1);
        check("ce_seg1_steps", mon_ev[1], 0);
        check("ce_pos_x", pos_x, 180);
        check("ce_pos_y", pos_y, 80);
        do_start(0);
        check("ce_err_cleared", err, 0);
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
